// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- IF stage of the 5-stage MIPS pipeline, upstream of decode.
//
// Owns the PC, drives the IMEM read address and registers the fetched word
// into the IF/ID latch. Supports a PC preset (SYS_load), decode stall,
// EX branch/jump redirect with flush, and halt after the last IMEM word.
// All state updates on the falling edge of SYS_clk, matching the other stages.
//
// Optional feature: define FETCH_PERF_CNT_EN to add saturating 16-bit
// fetch/stall performance counters (F_fetch_cnt, F_stall_cnt).
//
// Ports
//   SYS_clk           in   1   clock, state updates on negedge
//   SYS_reset         in   1   synchronous active-low reset
//   SYS_load          in   1   load PC from SYS_pc_val
//   SYS_pc_val        in   8   byte start address (zero-extended)
//   D_stall           in   1   decode hazard stall: hold PC and IF/ID
//   EX_redirect       in   1   taken branch/jump resolved in EX
//   EX_target         in   32  redirect byte address
//   IMEM_instruction  in   32  combinational IMEM read data for IMEM_PC
//   IMEM_PC           out  32  current PC
//   F_instruction     out  32  IF/ID instruction
//   F_pc_plus4        out  32  IF/ID PC+4 of F_instruction
//   F_valid           out  1   1 = real instruction, 0 = bubble
//   F_state           out  2   00 IDLE, 01 RUN, 10 HALT
//   F_fetch_cnt       out  16  (FETCH_PERF_CNT_EN) valid words latched
//   F_stall_cnt       out  16  (FETCH_PERF_CNT_EN) stalled RUN/HALT cycles
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] NOP_INSTR  = 32'h0
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        SYS_load,
  input  logic [7:0]  SYS_pc_val,
  input  logic        D_stall,
  input  logic        EX_redirect,
  input  logic [31:0] EX_target,
  input  logic [31:0] IMEM_instruction,
  output logic [31:0] IMEM_PC,
  output logic [31:0] F_instruction,
  output logic [31:0] F_pc_plus4,
  output logic        F_valid,
  output logic [1:0]  F_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] F_fetch_cnt,
  output logic [15:0] F_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] LAST_PC  = 32'(IMEM_WORDS * 4 - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Every PC write is word-aligned, so bits [1:0] are dropped at the source.
  logic [31:0] load_addr, target_addr, pc_plus4;
  assign load_addr   = {24'b0, SYS_pc_val[7:2], 2'b00};
  assign target_addr = {EX_target[31:2], 2'b00};
  assign pc_plus4    = pc_q + 32'd4;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(negedge SYS_clk) begin
    if (!SYS_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic. Priority: load > redirect > stall > normal fetch.
  // NOTE: state_d is given a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (SYS_load) begin
      state_d = (load_addr >= PC_LIMIT) ? ST_HALT : ST_RUN;
    end else if (state_q == ST_RUN || state_q == ST_HALT) begin
      if (EX_redirect)
        state_d = (target_addr >= PC_LIMIT) ? ST_HALT : ST_RUN;
      else if (state_q == ST_RUN && !D_stall && pc_q == LAST_PC)
        state_d = ST_HALT;
    end
  end

  // PC and IF/ID latch next values.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (SYS_load) begin
      pc_d    = load_addr;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN, ST_HALT: begin
          if (EX_redirect) begin
            pc_d    = target_addr;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
          end else if (D_stall) begin
            // Hold everything.
          end else if (state_q == ST_RUN) begin
            instr_d = IMEM_instruction;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            // The last word is still delivered, but the PC stops on it.
            if (pc_q != LAST_PC) pc_d = pc_plus4;
          end else begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
          end
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  // PC and IF/ID registers; reset overrides every other input.
  always_ff @(negedge SYS_clk) begin
    if (!SYS_reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Outputs.
  always_comb begin
    IMEM_PC       = pc_q;
    F_instruction = instr_q;
    F_pc_plus4    = pc4_q;
    F_valid       = valid_q;
    F_state       = state_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;

  // A valid word is latched only on a normal RUN fetch.
  assign fetch_inc = (state_q == ST_RUN) && !EX_redirect && !D_stall;
  assign stall_inc = (state_q == ST_RUN || state_q == ST_HALT) && D_stall && !EX_redirect;

  always_ff @(negedge SYS_clk) begin
    if (!SYS_reset || SYS_load) begin
      F_fetch_cnt <= 16'd0;
      F_stall_cnt <= 16'd0;
    end else begin
      if (fetch_inc && F_fetch_cnt != 16'hFFFF) F_fetch_cnt <= F_fetch_cnt + 16'd1;
      if (stall_inc && F_stall_cnt != 16'hFFFF) F_stall_cnt <= F_stall_cnt + 16'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
